sccb_cmd_arbiter: RTL
=====================

Name: sccb_cmd_arbiter

Overview:
- Round-robin arbiter and transaction scheduler sharing the single SCCB engine (sccb_fsm + sccb_timing_gen) between NUM_REQ requesters, e.g. the AXI4 control path and the sensor boot-init sequencer.
- Accepts one 3-phase SCCB command at a time and forwards it to the engine.
- Waits for completion or a timeout, returns the result to the owning requester, then enforces a bus-free gap before the next grant.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- TIMEOUT_CYC, 65535, max clk cycles between engine accept and fsm_done before abort.
- GAP_CYC, 16, idle clk cycles between consecutive SCCB transactions (>=1).
- CNT_W, 16, width of timeout/gap counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester command accept.
- req_rw  in  NUM_REQ  1=read, 0=write.
- req_dev_id  in  7*NUM_REQ  7-bit device ID, slice i = [7i+6:7i].
- req_sub_addr  in  8*NUM_REQ  register sub-address.
- req_wdata  in  8*NUM_REQ  write data.
- rsp_valid  out  NUM_REQ  response valid to owner.
- rsp_ready  in  NUM_REQ  response accept.
- rsp_rdata  out  8  read data, shared by all requesters.
- rsp_err  out  2  00 OK, 01 NACK, 10 timeout.
- fsm_cmd_valid  out  1  command to engine.
- fsm_cmd_ready  in  1  engine accepts command.
- fsm_rw  out  1  latched command field.
- fsm_dev_id  out  7  latched command field.
- fsm_sub_addr  out  8  latched command field.
- fsm_wdata  out  8  latched command field.
- fsm_done  in  1  one-cycle pulse, transaction finished.
- fsm_nack  in  1  valid with fsm_done.
- fsm_rdata  in  8  valid with fsm_done.
- fsm_abort  out  1  one-cycle pulse forcing engine to STOP/idle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst high at posedge): state IDLE, rr_ptr=0, all outputs 0, counters 0, latched fields 0. Reset mid-transaction drops everything without any response or abort pulse; the engine shares rst.
- States: IDLE, ISSUE, WAIT, RESP, GAP.

IDLE:
- grant = first i with req_valid[i], searching from rr_ptr upward with wrap.
- req_ready[grant]=1 combinationally; all other req_ready=0. req_ready is 0 in every other state.
- On handshake: latch the command, owner<=grant, rr_ptr<=(grant+1) mod NUM_REQ, go to ISSUE.
- No valid: stay; rr_ptr is unchanged.

ISSUE:
- fsm_cmd_valid=1, fields stable.
- On fsm_cmd_ready: clear timeout counter, go to WAIT. Handshake is same-cycle; fsm_cmd_valid drops the next cycle.

WAIT:
- Counter increments each cycle.
- fsm_done: capture rdata (read only; write captures 0x00) and err=fsm_nack?01:00, go to RESP.
- Counter reaches TIMEOUT_CYC-1 without done: fsm_abort=1 for that single cycle, err=10, rdata=0x00, go to RESP.
- fsm_done in the same cycle as timeout: done wins, no abort.

RESP:
- rsp_valid[owner]=1 with rsp_rdata/rsp_err held.
- On rsp_ready[owner]: load gap counter, go to GAP. rsp_ready of non-owners is ignored.

GAP:
- Count GAP_CYC cycles, then go to IDLE.

Ordering and latency:
- Minimum cycles from req handshake to rsp_valid = 2 + engine latency.
- Back-to-back grant no earlier than GAP_CYC+1 cycles after response accept.

Handshake rules:
- rsp_rdata and rsp_err are 0 when no rsp_valid is asserted.
- Requesters must hold req fields stable while req_valid=1 and ready=0.
- A requester dropping valid before grant is legal and simply not granted.

Test Plan:
- Single write, requester 0, dev 0x21, sub 0x12, data 0x80, engine done after 50 cycles, nack=0 -> fsm fields match, rsp_valid[0] with err=00, rdata=0x00, busy falls GAP_CYC+1 cycles after rsp handshake.
- Read, requester 1, sub 0x0A, engine returns rdata=0x76 -> rsp_valid[1], rsp_rdata=0x76, err=00.
- Both requesters valid continuously for 4 commands each -> grants alternate 0,1,0,1…; no requester granted twice while the other waits; rr_ptr wraps correctly.
- Engine never pulses fsm_done, TIMEOUT_CYC=100 -> fsm_abort single pulse exactly 100 cycles after cmd handshake, rsp_err=10; next command is then accepted normally.
- NACK case, plus fsm_done coincident with the timeout cycle -> err=01, fsm_abort stays 0.
- rst asserted in WAIT and in RESP -> next cycle all outputs 0, state IDLE, rr_ptr=0; the first grant afterwards goes to requester 0 when all are valid.

Source files
------------

// File: rtl/sccb_cmd_arbiter.sv
// Round-robin arbiter that shares one SCCB engine between NUM_REQ requesters,
// forwarding one command at a time and enforcing a bus-free gap between transactions.
module sccb_cmd_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 65535,
    parameter int GAP_CYC     = 16,
    parameter int CNT_W       = 16,
    localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [7*NUM_REQ-1:0] req_dev_id,
    input  logic [8*NUM_REQ-1:0] req_sub_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [7:0]           rsp_rdata,
    output logic [1:0]           rsp_err,
    output logic                 fsm_cmd_valid,
    input  logic                 fsm_cmd_ready,
    output logic                 fsm_rw,
    output logic [6:0]           fsm_dev_id,
    output logic [7:0]           fsm_sub_addr,
    output logic [7:0]           fsm_wdata,
    input  logic                 fsm_done,
    input  logic                 fsm_nack,
    input  logic [7:0]           fsm_rdata,
    output logic                 fsm_abort,
    output logic                 busy,
    output logic [2:0]           state_dbg,
    output logic [PTR_W-1:0]     rr_ptr_dbg
);

    // Handshakes: a transfer happens on a rising clk edge where both valid and
    // ready are high; valid never waits on ready, and the payload is held while valid.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic [7:0]       rdata_q;
    logic [1:0]       err_q;

    logic             grant_found;
    logic [PTR_W-1:0] grant;
    int               idx;
    logic             sel_rw;
    logic [6:0]       sel_dev_id;
    logic [7:0]       sel_sub_addr;
    logic [7:0]       sel_wdata;
    logic             owner_rsp_ready;

    // Search starts at rr_ptr and wraps, so the last winner has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && req_valid[PTR_W'(idx)]) begin
                grant_found = 1'b1;
                grant       = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        sel_rw          = 1'b0;
        sel_dev_id      = '0;
        sel_sub_addr    = '0;
        sel_wdata       = '0;
        owner_rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == PTR_W'(i)) begin
                sel_rw       = req_rw[i];
                sel_dev_id   = req_dev_id[7*i +: 7];
                sel_sub_addr = req_sub_addr[8*i +: 8];
                sel_wdata    = req_wdata[8*i +: 8];
            end
            if (owner == PTR_W'(i)) owner_rsp_ready = rsp_ready[i];
        end
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        rsp_valid     = '0;
        fsm_cmd_valid = 1'b0;
        fsm_abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready[grant] = 1'b1;
                    state_nxt        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fsm_cmd_valid = 1'b1;
                if (fsm_cmd_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A done pulse on the final cycle still wins over the abort.
                if (fsm_done) begin
                    state_nxt = S_RESP;
                end else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    fsm_abort = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[owner] = 1'b1;
                if (owner_rsp_ready) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == '0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            to_cnt       <= '0;
            gap_cnt      <= '0;
            rdata_q      <= '0;
            err_q        <= '0;
            fsm_rw       <= 1'b0;
            fsm_dev_id   <= '0;
            fsm_sub_addr <= '0;
            fsm_wdata    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        fsm_rw       <= sel_rw;
                        fsm_dev_id   <= sel_dev_id;
                        fsm_sub_addr <= sel_sub_addr;
                        fsm_wdata    <= sel_wdata;
                        owner        <= grant;
                        rr_ptr       <= (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (fsm_cmd_ready) to_cnt <= '0;
                end
                S_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (fsm_done) begin
                        rdata_q <= fsm_rw ? fsm_rdata : 8'h00;
                        err_q   <= fsm_nack ? 2'b01 : 2'b00;
                    end else if (fsm_abort) begin
                        rdata_q <= 8'h00;
                        err_q   <= 2'b10;
                    end
                end
                S_RESP: begin
                    if (owner_rsp_ready) gap_cnt <= CNT_W'(GAP_CYC - 1);
                end
                S_GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_rdata  = (state == S_RESP) ? rdata_q : 8'h00;
    assign rsp_err    = (state == S_RESP) ? err_q : 2'b00;
    assign busy       = (state != S_IDLE);
    assign state_dbg  = state;
    assign rr_ptr_dbg = rr_ptr;

endmodule
